fifod2udp_tx: RTL and testbench



---
 rtl/fifod2udp_tx.sv | 122 ++++++++++++
 tb/tb_fifod2udp_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifod2udp_tx.sv
// Transmit bridge: drains a length-delimited payload from fifod into the MAC UDP
// transmit port, using the fs/fd start/done handshake with the console.
module fifod2udp_tx #(
  parameter logic [11:0] MAX_LEN      = 12'd1472,
  parameter logic [15:0] PREP_TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fs,
  output logic        fd,
  output logic        err,
  input  logic [11:0] data_len,
  output logic [11:0] udp_tx_len,
  output logic        flag_udp_tx_req,
  input  logic        flag_udp_tx_prep,
  output logic        udp_txen,
  output logic [7:0]  udp_txd,
  output logic        fifod_rxen,
  input  logic [7:0]  fifod_rxd,
  input  logic        fifod_empty
);

  typedef enum logic [2:0] {IDLE, CHECK, REQ, READ, DONE} state_t;

  state_t      state, state_next;
  logic [11:0] len_r;
  logic [11:0] rd_cnt;
  logic [11:0] wr_cnt;
  logic [15:0] tmo_cnt;
  logic        vld_p0;
  logic        start;
  logic        err_next;
  logic        last_byte;
  logic        tmo_hit;

  // Reads stop at len_r bytes and never touch an empty FIFO; held off during reset.
  assign fifod_rxen = rst_n && (state == READ) && !fifod_empty && (rd_cnt < len_r);
  assign last_byte  = udp_txen && (wr_cnt == len_r - 12'd1);
  assign tmo_hit    = (tmo_cnt == PREP_TIMEOUT - 16'd1);

  always_comb begin
    state_next = state;
    err_next   = err;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (fs && !fd) begin
          start      = 1'b1;
          err_next   = 1'b0;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (len_r == 12'd0) begin
          state_next = DONE;
        end else if (len_r > MAX_LEN) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (flag_udp_tx_prep) begin
          state_next = READ;
        end else if (tmo_hit) begin
          err_next   = 1'b1;
          state_next = DONE;
        end
      end
      READ: begin
        if (last_byte) state_next = DONE;
      end
      DONE: begin
        if (!fs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      fd              <= 1'b0;
      err             <= 1'b0;
      flag_udp_tx_req <= 1'b0;
      len_r           <= 12'd0;
      udp_tx_len      <= 12'd0;
      rd_cnt          <= 12'd0;
      wr_cnt          <= 12'd0;
      tmo_cnt         <= 16'd0;
      vld_p0          <= 1'b0;
      udp_txen        <= 1'b0;
      udp_txd         <= 8'd0;
    end else begin
      state           <= state_next;
      fd              <= (state_next == DONE);
      err             <= err_next;
      flag_udp_tx_req <= (state_next == REQ);

      if (start) begin
        len_r      <= data_len;
        udp_tx_len <= data_len;
        rd_cnt     <= 12'd0;
        wr_cnt     <= 12'd0;
      end else begin
        if (fifod_rxen) rd_cnt <= rd_cnt + 12'd1;
        if (udp_txen)   wr_cnt <= wr_cnt + 12'd1;
      end

      if (state != REQ)           tmo_cnt <= 16'd0;
      else if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;

      // p0: read issued last cycle, fifod_rxd now valid
      vld_p0 <= fifod_rxen;
      // p1: byte presented to the MAC
      udp_txen <= vld_p0;
      if (vld_p0) udp_txd <= fifod_rxd;
    end
  end

endmodule

// File: tb/tb_fifod2udp_tx.sv
// Directed bench for fifod2udp_tx: FIFO and MAC prep models plus hand-computed expectations.
module tb_fifod2udp_tx;

  logic        clk = 1'b0;
  logic        rst_n, fs, fd, err;
  logic [11:0] data_len, udp_tx_len;
  logic        flag_udp_tx_req, flag_udp_tx_prep;
  logic        udp_txen, fifod_rxen, fifod_empty;
  logic [7:0]  udp_txd, fifod_rxd;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic [7:0] pend[$];
  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  int n_req = 0, n_rxen = 0, n_viol = 0;
  int gap = 0, max_gap = 0;
  int hold = 0, hold_cnt = 0;
  int prep_delay = 0, seen = 0;
  bit prep_en = 1'b0;
  bit pop_req = 1'b0;

  fifod2udp_tx #(.MAX_LEN(12'd1472), .PREP_TIMEOUT(16'd16)) dut (
    .clk(clk), .rst_n(rst_n), .fs(fs), .fd(fd), .err(err),
    .data_len(data_len), .udp_tx_len(udp_tx_len),
    .flag_udp_tx_req(flag_udp_tx_req), .flag_udp_tx_prep(flag_udp_tx_prep),
    .udp_txen(udp_txen), .udp_txd(udp_txd),
    .fifod_rxen(fifod_rxen), .fifod_rxd(fifod_rxd), .fifod_empty(fifod_empty)
  );

  always #5 clk = ~clk;

  // fifod model: pending bytes are released after `hold` empty cycles
  always @(negedge clk) begin
    if (q.size() == 0 && pend.size() > 0) begin
      if (hold_cnt >= hold) begin
        while (pend.size() > 0) q.push_back(pend.pop_front());
        hold_cnt = 0;
      end else begin
        hold_cnt++;
      end
    end
    fifod_empty = (q.size() == 0);
    #1;
    pop_req = fifod_rxen;
    if (fifod_rxen) begin
      n_rxen++;
      if (fifod_empty) n_viol++;
    end
  end

  always @(posedge clk) if (pop_req && q.size() > 0) fifod_rxd <= q.pop_front();

  // MAC side: collect bytes, measure bubbles, answer req after prep_delay cycles
  always @(negedge clk) begin
    if (udp_txen) begin
      if (out_q.size() > 0 && gap > max_gap) max_gap = gap;
      gap = 0;
      out_q.push_back(udp_txd);
    end else if (out_q.size() > 0) begin
      gap++;
    end
    if (flag_udp_tx_req) n_req++;
    if (prep_en && flag_udp_tx_req) begin
      if (seen >= prep_delay) flag_udp_tx_prep = 1'b1;
      seen++;
    end else begin
      flag_udp_tx_prep = 1'b0;
      seen = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic clr();
    q.delete();
    pend.delete();
    exp_q.delete();
    hold_cnt = 0;
  endtask

  task automatic load(input int n, input int base, input int step, input bit to_pend);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'(base + i * step);
      if (to_pend) pend.push_back(b);
      else         q.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic start(input logic [11:0] len, input int dly, input bit en);
    out_q.delete();
    n_req = 0; n_rxen = 0; n_viol = 0; gap = 0; max_gap = 0;
    prep_delay = dly;
    prep_en = en;
    data_len = len;
    fs = 1'b1;
  endtask

  task automatic stop();
    fs = 1'b0;
    wait_cyc(2);
  endtask

  task automatic wait_fd(input string tag, input int bound);
    int k;
    k = 0;
    while (!fd && k < bound) begin
      wait_cyc();
      k++;
    end
    chk({tag, "_fd"}, 32'(fd), 32'd1);
  endtask

  task automatic check_data(input string tag);
    int nerr;
    int n;
    nerr = 0;
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    chk({tag, "_count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) if (out_q[i] !== exp_q[i]) nerr++;
    chk({tag, "_data"}, nerr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    rst_n = 1'b0; fs = 1'b0; data_len = 12'd0;
    flag_udp_tx_prep = 1'b0; fifod_empty = 1'b1; fifod_rxd = 8'd0;
    wait_cyc(3);
    chk("rst_fd", 32'(fd), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_req", 32'(flag_udp_tx_req), 0);
    chk("rst_txen", 32'(udp_txen), 0);
    chk("rst_rxen", 32'(fifod_rxen), 0);
    chk("rst_txlen", 32'(udp_tx_len), 0);
    rst_n = 1'b1;
    wait_cyc(2);

    // nominal 4-byte transfer, prep 3 cycles after req
    clr(); load(4, 8'h11, 8'h11, 1'b0); wait_cyc();
    start(12'd4, 3, 1'b1);
    wait_fd("t1", 60);
    check_data("t1");
    chk("t1_req", n_req, 4);
    chk("t1_rxen", n_rxen, 4);
    chk("t1_gap", max_gap, 0);
    chk("t1_txlen", 32'(udp_tx_len), 4);
    chk("t1_err", 32'(err), 0);
    chk("t1_viol", n_viol, 0);
    stop();

    // underrun: 3 bytes, 5 empty cycles, 3 more
    clr(); hold = 5;
    load(3, 8'h50, 1, 1'b0); load(3, 8'h53, 1, 1'b1); wait_cyc();
    start(12'd6, 1, 1'b1);
    wait_fd("t2", 80);
    check_data("t2");
    chk("t2_gap", max_gap, 5);
    chk("t2_rxen", n_rxen, 6);
    chk("t2_viol", n_viol, 0);
    stop(); hold = 0;

    // zero length
    clr(); start(12'd0, 0, 1'b1);
    wait_cyc(2);
    chk("t3z_fd", 32'(fd), 1);
    chk("t3z_err", 32'(err), 0);
    chk("t3z_req", n_req, 0);
    chk("t3z_rxen", n_rxen, 0);
    stop();

    // oversize
    start(12'd1500, 0, 1'b1);
    wait_cyc(2);
    chk("t3o_fd", 32'(fd), 1);
    chk("t3o_err", 32'(err), 1);
    chk("t3o_req", n_req, 0);
    stop();

    // maximum length
    clr(); load(1472, 0, 1, 1'b0); wait_cyc();
    start(12'd1472, 0, 1'b1);
    wait_fd("t3m", 1600);
    check_data("t3m");
    chk("t3m_err", 32'(err), 0);
    chk("t3m_rxen", n_rxen, 1472);
    stop();

    // prep never comes
    clr(); load(5, 8'hA0, 1, 1'b0); wait_cyc();
    start(12'd5, 0, 1'b0);
    wait_fd("t4", 40);
    chk("t4_req", n_req, 16);
    chk("t4_err", 32'(err), 1);
    chk("t4_rxen", n_rxen, 0);
    stop();

    // reset after two of eight bytes
    clr(); load(8, 8'h30, 1, 1'b0); wait_cyc();
    start(12'd8, 0, 1'b1);
    k = 0;
    while (out_q.size() < 2 && k < 40) begin
      wait_cyc();
      k++;
    end
    chk("t5_two", out_q.size(), 2);
    rst_n = 1'b0; fs = 1'b0;
    wait_cyc();
    rst_n = 1'b1;
    #1;
    chk("t5_fd", 32'(fd), 0);
    chk("t5_req", 32'(flag_udp_tx_req), 0);
    chk("t5_txen", 32'(udp_txen), 0);
    chk("t5_txd", 32'(udp_txd), 0);
    chk("t5_txlen", 32'(udp_tx_len), 0);
    chk("t5_rxen", 32'(fifod_rxen), 0);
    wait_cyc();
    clr(); load(3, 8'hAA, 8'h11, 1'b0); wait_cyc();
    start(12'd3, 0, 1'b1);
    wait_fd("t5b", 40);
    check_data("t5b");
    chk("t5b_err", 32'(err), 0);

    // fs held after done: no re-trigger
    wait_cyc(10);
    chk("t6_req", n_req, 1);
    chk("t6_hold", 32'(fd), 1);
    stop();
    start(12'd1500, 0, 1'b1);
    wait_cyc(2);
    chk("t6_err", 32'(err), 1);
    n_req = 0;
    wait_cyc(5);
    chk("t6_noreq", n_req, 0);
    fs = 1'b0;
    wait_cyc();
    chk("t6_fdlow", 32'(fd), 0);
    clr(); load(2, 8'h5A, 1, 1'b0);
    start(12'd2, 0, 1'b1);
    wait_cyc();
    chk("t6_errclr", 32'(err), 0);
    wait_fd("t6b", 40);
    check_data("t6b");
    chk("t6b_err", 32'(err), 0);
    stop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
